// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the RV32I field packer: op selects, major opcodes,
// funct3/funct7 values and the legality helper used at the input handshake.
package instr_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LW  = 3'd4,
        OP_SW  = 3'd5,
        OP_BEQ = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Only the one spare encoding is rejected; BEQ occupies 3'b110.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != OP_ILL);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: turns an op select plus register/immediate
// fields into a 32-bit RV32I instruction word.
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] instr
);

    // Branch offset is imm scaled by two, so bit 0 of the offset is implicit.
    logic [12:0] br_off;
    assign br_off = {imm, 1'b0};

    // Select the instruction format for the op and assemble its fields.
    always_comb begin
        instr = 32'd0;
        case (op)
            OP_ADD:  instr = {F7_BASE, rs2, rs1, F3_ADDSUB, rd, OPC_RTYPE};
            OP_SUB:  instr = {F7_SUB,  rs2, rs1, F3_ADDSUB, rd, OPC_RTYPE};
            OP_AND:  instr = {F7_BASE, rs2, rs1, F3_AND,    rd, OPC_RTYPE};
            OP_OR:   instr = {F7_BASE, rs2, rs1, F3_OR,     rd, OPC_RTYPE};
            OP_LW:   instr = {imm, rs1, F3_WORD, rd, OPC_LOAD};
            OP_SW:   instr = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            OP_BEQ:  instr = {br_off[12], br_off[10:5], rs2, rs1, F3_BEQ,
                              br_off[4:1], br_off[11], OPC_BRANCH};
            default: instr = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field sets, packs them into RV32I
// words and streams them with consecutive byte addresses into instruction
// memory through a single registered output stage.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [11:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          full,
    output logic          err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] LAST_IDX = (IW+1)'(DEPTH - 1);
    localparam logic [IW:0] IDX_ONE  = (IW+1)'(1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1
    } state_e;

    state_e        state_p1;
    logic [IW:0]   index_p1;
    logic          full_p1;
    logic          err_p1;
    logic          vld_p1;
    logic [31:0]   instr_p1;
    logic [AW-1:0] addr_p1;

    logic [31:0]   instr_p0;
    logic [AW-1:0] addr_p0;
    logic          legal_p0;
    logic          accept_p0;
    logic          illegal_p0;

    instr_pack u_pack (
        .op    (in_op),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .instr (instr_p0)
    );

    assign vld_p1     = (state_p1 == ST_LOADED);
    assign legal_p0   = op_is_legal(in_op);
    assign in_ready   = !full_p1 && (!vld_p1 || out_ready);
    assign accept_p0  = in_valid && in_ready && legal_p0;
    assign illegal_p0 = in_valid && in_ready && !legal_p0;
    assign addr_p0    = AW'({index_p1[IW-1:0], 2'b00});

    // ---- stage p0 -> p1: handshake FSM, write index, full and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ST_EMPTY;
            index_p1 <= '0;
            full_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else if (flush) begin
            state_p1 <= ST_EMPTY;
            index_p1 <= '0;
            full_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            if (accept_p0) begin
                state_p1 <= ST_LOADED;
                index_p1 <= index_p1 + IDX_ONE;
                if (index_p1 == LAST_IDX)
                    full_p1 <= 1'b1;
            end else if (vld_p1 && out_ready) begin
                state_p1 <= ST_EMPTY;
            end
            if (illegal_p0)
                err_p1 <= 1'b1;
        end
    end

    // Capture the packed word and its address on every accepted field set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= 32'd0;
            addr_p1  <= '0;
        end else if (accept_p0 && !flush) begin
            instr_p1 <= instr_p0;
            addr_p1  <= addr_p0;
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_addr  = addr_p1;
    assign full      = full_p1;
    assign err       = err_p1;

endmodule
